axi2mem_tcdm_sched: RTL and testbench

AXI2MEM_TCDM_SCHED -- requirements
Module: axi2mem_tcdm_sched

---
 rtl/axi2mem_pkg.sv | 19 +
 rtl/axi2mem_buffer.sv | 64 ++++++
 rtl/axi2mem_tcdm_sched.sv | 183 ++++++++++++++++++
 tb/tb_axi2mem_tcdm_sched.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi2mem_pkg.sv
// Shared types and widths for the AXI-to-TCDM memory bridge.
// Holds the beat scheduler state encoding and the ID/data/strobe widths
// used by the scheduler and its read-ID buffer.
package axi2mem_pkg;

  localparam int ID_WIDTH   = 6;
  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int STRB_WIDTH = 4;

  // Scheduler FSM encoding, kept as plain constants so legacy tools that
  // dislike enums in ports and hierarchical references still read it.
  typedef logic [1:0] sched_state_t;

  localparam sched_state_t ST_ARB     = 2'd0;
  localparam sched_state_t ST_RD_BEAT = 2'd1;
  localparam sched_state_t ST_WR_BEAT = 2'd2;

endpackage

// File: rtl/axi2mem_buffer.sv
// Small synchronous FIFO used to remember {last, id} of read beats that
// have been issued to TCDM but whose response has not been pushed yet.
// Push is ignored when full and pop is ignored when empty, so neither
// pointer can run past the stored data.
module axi2mem_buffer #(
  parameter int DATA_WIDTH   = 7,
  parameter int BUFFER_DEPTH = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_pop,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_empty,
  output logic                  o_full
);

  localparam int PTR_W = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
  localparam int CNT_W = $clog2(BUFFER_DEPTH + 1);

  logic [DATA_WIDTH-1:0] r_mem [BUFFER_DEPTH];
  logic [PTR_W-1:0]      r_wrPtr;
  logic [PTR_W-1:0]      r_rdPtr;
  logic [CNT_W-1:0]      r_count;
  logic                  w_push;
  logic                  w_pop;

  function automatic logic [PTR_W-1:0] ptrInc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUFFER_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CNT_W'(BUFFER_DEPTH));
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = r_mem[r_rdPtr];

  // Storage and pointers; storage is cleared so the head reads 0 in reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < BUFFER_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wrPtr] <= i_data;
        r_wrPtr        <= ptrInc(r_wrPtr);
      end
      if (w_pop) begin
        r_rdPtr <= ptrInc(r_rdPtr);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/axi2mem_tcdm_sched.sv
// Beat scheduler between the AXI transfer units and a 2-port (2x32-bit)
// TCDM interface. Each 64-bit beat is split into two 32-bit TCDM requests
// at addr and addr+4. Reads are limited by RD_CREDITS outstanding beats;
// writes need both halves of write data available.
// Optional feature: define AXI2MEM_SCHED_WR_PRIO_EN to make writes win
// arbitration whenever eligible (default is read/write round-robin).
module axi2mem_tcdm_sched
  import axi2mem_pkg::*;
#(
  parameter int RD_CREDITS = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       rd_cmd_valid_i,
  output logic                       rd_cmd_ready_o,
  input  logic [ADDR_WIDTH-1:0]      rd_cmd_addr_i,
  input  logic [ID_WIDTH-1:0]        rd_cmd_id_i,
  input  logic                       rd_cmd_last_i,
  input  logic                       wr_cmd_valid_i,
  output logic                       wr_cmd_ready_o,
  input  logic [ADDR_WIDTH-1:0]      wr_cmd_addr_i,
  input  logic [1:0]                 wr_dat_gnt_i,
  output logic [1:0]                 wr_dat_req_o,
  input  logic [1:0][DATA_WIDTH-1:0] wr_dat_i,
  input  logic [1:0][STRB_WIDTH-1:0] wr_strb_i,
  output logic [1:0]                 tcdm_req_o,
  input  logic [1:0]                 tcdm_gnt_i,
  output logic [1:0][ADDR_WIDTH-1:0] tcdm_add_o,
  output logic [1:0]                 tcdm_wen_o,
  output logic [1:0][DATA_WIDTH-1:0] tcdm_wdata_o,
  output logic [1:0][STRB_WIDTH-1:0] tcdm_be_o,
  input  logic [1:0]                 tcdm_r_valid_i,
  input  logic [1:0][DATA_WIDTH-1:0] tcdm_r_rdata_i,
  output logic [1:0]                 rd_push_req_o,
  output logic [1:0][DATA_WIDTH-1:0] rd_push_dat_o,
  output logic [ID_WIDTH-1:0]        rd_push_id_o,
  output logic                       rd_push_last_o
);

  localparam int CNT_W  = $clog2(RD_CREDITS + 1);
  localparam int FIFO_W = ID_WIDTH + 1;

  sched_state_t          r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [1:0]            r_done;
  logic                  r_prefWr;
  logic [CNT_W-1:0]      r_outCnt;

  logic                  w_inArb;
  logic                  w_inBeat;
  logic                  w_rdElig;
  logic                  w_wrElig;
  logic                  w_pickRd;
  logic                  w_pickWr;
  logic [1:0]            w_grant;
  logic [1:0]            w_doneNext;
  logic                  w_pop;
  logic                  w_fifoEmpty;
  logic                  w_fifoFull;
  logic [FIFO_W-1:0]     w_fifoHead;

  assign w_inArb    = (r_state == ST_ARB);
  assign w_inBeat   = (r_state == ST_RD_BEAT) || (r_state == ST_WR_BEAT);
  assign w_rdElig   = rd_cmd_valid_i && (r_outCnt < CNT_W'(RD_CREDITS)) && !w_fifoFull;
  assign w_wrElig   = wr_cmd_valid_i && (wr_dat_gnt_i == 2'b11);
  assign w_grant    = tcdm_req_o & tcdm_gnt_i;
  assign w_doneNext = r_done | w_grant;
  assign w_pop      = tcdm_r_valid_i[0] && !w_fifoEmpty;

  // Pick the next beat in ARB: fixed write priority or read/write round-robin.
  always_comb begin
    w_pickRd = 1'b0;
    w_pickWr = 1'b0;
    if (w_inArb) begin
`ifdef AXI2MEM_SCHED_WR_PRIO_EN
      w_pickWr = w_wrElig;
      w_pickRd = w_rdElig && !w_wrElig;
`else
      if (w_rdElig && w_wrElig) begin
        w_pickWr = r_prefWr;
        w_pickRd = !r_prefWr;
      end else begin
        w_pickRd = w_rdElig;
        w_pickWr = w_wrElig;
      end
`endif
    end
  end

  assign rd_cmd_ready_o = w_pickRd;
  assign wr_cmd_ready_o = w_pickWr;

  // Beat FSM: latch the chosen command, then hold until both ports granted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= ST_ARB;
      r_addr   <= '0;
      r_done   <= 2'b00;
      r_prefWr <= 1'b0;
    end else begin
      case (r_state)
        ST_ARB: begin
          r_done <= 2'b00;
          if (w_pickRd) begin
            r_state  <= ST_RD_BEAT;
            r_addr   <= rd_cmd_addr_i;
            r_prefWr <= 1'b1;
          end else if (w_pickWr) begin
            r_state  <= ST_WR_BEAT;
            r_addr   <= wr_cmd_addr_i;
            r_prefWr <= 1'b0;
          end
        end
        ST_RD_BEAT, ST_WR_BEAT: begin
          if (w_doneNext == 2'b11) begin
            r_state <= ST_ARB;
            r_done  <= 2'b00;
          end else begin
            r_done <= w_doneNext;
          end
        end
        default: begin
          r_state <= ST_ARB;
          r_done  <= 2'b00;
        end
      endcase
    end
  end

  // Outstanding read beats: +1 on acceptance, -1 when port 0 response pops.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_outCnt <= '0;
    end else if (w_pickRd && !w_pop) begin
      r_outCnt <= r_outCnt + CNT_W'(1);
    end else if (w_pop && !w_pickRd) begin
      r_outCnt <= r_outCnt - CNT_W'(1);
    end
  end

  // TCDM request side; everything is forced to 0 outside a beat state.
  always_comb begin
    tcdm_req_o    = 2'b00;
    tcdm_add_o    = '0;
    tcdm_wen_o    = 2'b00;
    tcdm_wdata_o  = '0;
    tcdm_be_o     = '0;
    wr_dat_req_o  = 2'b00;
    if (w_inBeat) begin
      tcdm_req_o    = ~r_done;
      tcdm_add_o[0] = r_addr;
      tcdm_add_o[1] = r_addr + 32'd4;
    end
    if (r_state == ST_RD_BEAT) begin
      tcdm_wen_o = 2'b11;
    end
    if (r_state == ST_WR_BEAT) begin
      tcdm_wdata_o = wr_dat_i;
      tcdm_be_o    = wr_strb_i;
      wr_dat_req_o = (~r_done) & tcdm_gnt_i;
    end
  end

  // Read responses pass straight through; held quiet while in reset.
  assign rd_push_req_o = rst_ni ? tcdm_r_valid_i : 2'b00;
  assign rd_push_dat_o = rst_ni ? tcdm_r_rdata_i : '0;
  assign {rd_push_last_o, rd_push_id_o} = w_fifoHead;

  axi2mem_buffer #(
    .DATA_WIDTH   (FIFO_W),
    .BUFFER_DEPTH (RD_CREDITS)
  ) i_id_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .i_push  (w_pickRd),
    .i_data  ({rd_cmd_last_i, rd_cmd_id_i}),
    .i_pop   (w_pop),
    .o_data  (w_fifoHead),
    .o_empty (w_fifoEmpty),
    .o_full  (w_fifoFull)
  );

endmodule

// File: tb/tb_axi2mem_tcdm_sched.sv
// Directed testbench for axi2mem_tcdm_sched. Inputs change 1 time unit
// after the rising edge; outputs are checked 1 unit later.
module tb_axi2mem_tcdm_sched;
  import axi2mem_pkg::*;

  logic              clk_i;
  logic              rst_ni;
  logic              rd_cmd_valid_i;
  logic              rd_cmd_ready_o;
  logic [31:0]       rd_cmd_addr_i;
  logic [5:0]        rd_cmd_id_i;
  logic              rd_cmd_last_i;
  logic              wr_cmd_valid_i;
  logic              wr_cmd_ready_o;
  logic [31:0]       wr_cmd_addr_i;
  logic [1:0]        wr_dat_gnt_i;
  logic [1:0]        wr_dat_req_o;
  logic [1:0][31:0]  wr_dat_i;
  logic [1:0][3:0]   wr_strb_i;
  logic [1:0]        tcdm_req_o;
  logic [1:0]        tcdm_gnt_i;
  logic [1:0][31:0]  tcdm_add_o;
  logic [1:0]        tcdm_wen_o;
  logic [1:0][31:0]  tcdm_wdata_o;
  logic [1:0][3:0]   tcdm_be_o;
  logic [1:0]        tcdm_r_valid_i;
  logic [1:0][31:0]  tcdm_r_rdata_i;
  logic [1:0]        rd_push_req_o;
  logic [1:0][31:0]  rd_push_dat_o;
  logic [5:0]        rd_push_id_o;
  logic              rd_push_last_o;

  int nAsserts = 0;
  int nFails   = 0;

  axi2mem_tcdm_sched #(.RD_CREDITS(2)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .rd_cmd_valid_i (rd_cmd_valid_i),
    .rd_cmd_ready_o (rd_cmd_ready_o),
    .rd_cmd_addr_i  (rd_cmd_addr_i),
    .rd_cmd_id_i    (rd_cmd_id_i),
    .rd_cmd_last_i  (rd_cmd_last_i),
    .wr_cmd_valid_i (wr_cmd_valid_i),
    .wr_cmd_ready_o (wr_cmd_ready_o),
    .wr_cmd_addr_i  (wr_cmd_addr_i),
    .wr_dat_gnt_i   (wr_dat_gnt_i),
    .wr_dat_req_o   (wr_dat_req_o),
    .wr_dat_i       (wr_dat_i),
    .wr_strb_i      (wr_strb_i),
    .tcdm_req_o     (tcdm_req_o),
    .tcdm_gnt_i     (tcdm_gnt_i),
    .tcdm_add_o     (tcdm_add_o),
    .tcdm_wen_o     (tcdm_wen_o),
    .tcdm_wdata_o   (tcdm_wdata_o),
    .tcdm_be_o      (tcdm_be_o),
    .tcdm_r_valid_i (tcdm_r_valid_i),
    .tcdm_r_rdata_i (tcdm_r_rdata_i),
    .rd_push_req_o  (rd_push_req_o),
    .rd_push_dat_o  (rd_push_dat_o),
    .rd_push_id_o   (rd_push_id_o),
    .rd_push_last_o (rd_push_last_o)
  );

  // Free-running 10-unit clock.
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Advance to just after the next rising edge(s), where inputs are driven.
  task automatic applyStimulus(input int cycles);
    repeat (cycles) @(posedge clk_i);
    #1;
  endtask

  // One counted comparison of an observed value against its expectation.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFails++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected ready pattern for the contended read/write run (bit k = read).
  logic [3:0] expRdOrder;
  logic [1:0] expFirstPick;
  logic       prevRead;

  // Linear directed sequence.
  initial begin
`ifdef AXI2MEM_SCHED_WR_PRIO_EN
    expRdOrder   = 4'b0000;
    expFirstPick = 2'b01;
`else
    expRdOrder   = 4'b0101;
    expFirstPick = 2'b10;
`endif
    rst_ni         = 1'b0;
    rd_cmd_valid_i = 1'b0;
    rd_cmd_addr_i  = '0;
    rd_cmd_id_i    = '0;
    rd_cmd_last_i  = 1'b0;
    wr_cmd_valid_i = 1'b0;
    wr_cmd_addr_i  = '0;
    wr_dat_gnt_i   = 2'b00;
    wr_dat_i       = '0;
    wr_strb_i      = '0;
    tcdm_gnt_i     = 2'b00;
    tcdm_r_valid_i = 2'b00;
    tcdm_r_rdata_i = '0;

    // Reset state
    #12;
    checkOutput("rst_rd_ready", rd_cmd_ready_o, 0);
    checkOutput("rst_wr_ready", wr_cmd_ready_o, 0);
    checkOutput("rst_tcdm_req", tcdm_req_o, 0);
    checkOutput("rst_tcdm_add", tcdm_add_o, 0);
    checkOutput("rst_push_id", {rd_push_last_o, rd_push_id_o}, 0);
    rst_ni = 1'b1;

    // Single read beat, both grants immediate
    applyStimulus(1);
    $display("[TB] read beat 0x100 id 5");
    rd_cmd_valid_i = 1'b1; rd_cmd_addr_i = 32'h100; rd_cmd_id_i = 6'd5; rd_cmd_last_i = 1'b1;
    tcdm_gnt_i = 2'b11;
    #1;
    checkOutput("r1_rd_ready", {rd_cmd_ready_o, wr_cmd_ready_o}, 2'b10);
    applyStimulus(1);
    rd_cmd_valid_i = 1'b0;
    #1;
    checkOutput("r1_req", tcdm_req_o, 2'b11);
    checkOutput("r1_add", tcdm_add_o, {32'h104, 32'h100});
    checkOutput("r1_wen", tcdm_wen_o, 2'b11);
    applyStimulus(1);
    tcdm_gnt_i = 2'b00; tcdm_r_valid_i = 2'b11; tcdm_r_rdata_i = {32'hBBBB_0001, 32'hAAAA_0000};
    #1;
    checkOutput("r1_push_req", rd_push_req_o, 2'b11);
    checkOutput("r1_push_dat", rd_push_dat_o, {32'hBBBB_0001, 32'hAAAA_0000});
    checkOutput("r1_push_id", {rd_push_last_o, rd_push_id_o}, {1'b1, 6'd5});
    checkOutput("r1_req_idle", tcdm_req_o, 2'b00);
    applyStimulus(1);
    tcdm_r_valid_i = 2'b00;
    #1;
    checkOutput("r1_out_cnt", dut.r_outCnt, 0);
    checkOutput("r1_push_off", rd_push_req_o, 2'b00);

    // Write beat, port 1 grant delayed to its third requesting cycle
    $display("[TB] write beat 0x200, port 1 grant delayed");
    wr_cmd_valid_i = 1'b1; wr_cmd_addr_i = 32'h200; wr_dat_gnt_i = 2'b11;
    wr_dat_i = {32'h2222_2222, 32'h1111_1111}; wr_strb_i = {4'hC, 4'h3};
    #1;
    checkOutput("w1_wr_ready", {rd_cmd_ready_o, wr_cmd_ready_o}, 2'b01);
    applyStimulus(1);
    wr_cmd_valid_i = 1'b0; tcdm_gnt_i = 2'b01;
    #1;
    checkOutput("w1_req_c0", tcdm_req_o, 2'b11);
    checkOutput("w1_datreq_c0", wr_dat_req_o, 2'b01);
    checkOutput("w1_wdata", tcdm_wdata_o, {32'h2222_2222, 32'h1111_1111});
    checkOutput("w1_be", tcdm_be_o, {4'hC, 4'h3});
    checkOutput("w1_wen", tcdm_wen_o, 2'b00);
    checkOutput("w1_add", tcdm_add_o, {32'h204, 32'h200});
    applyStimulus(1);
    tcdm_gnt_i = 2'b00;
    #1;
    checkOutput("w1_req_c1", tcdm_req_o, 2'b10);
    checkOutput("w1_datreq_c1", wr_dat_req_o, 2'b00);
    applyStimulus(1);
    tcdm_gnt_i = 2'b10;
    #1;
    checkOutput("w1_req_c2", tcdm_req_o, 2'b10);
    checkOutput("w1_datreq_c2", wr_dat_req_o, 2'b10);
    applyStimulus(1);
    tcdm_gnt_i = 2'b11;
    #1;
    checkOutput("w1_req_end", tcdm_req_o, 2'b00);
    checkOutput("w1_state_arb", dut.r_state, ST_ARB);

    // Read and write both continuously valid
    $display("[TB] contended read/write run");
    rd_cmd_valid_i = 1'b1; rd_cmd_addr_i = 32'h300; rd_cmd_id_i = 6'd7; rd_cmd_last_i = 1'b0;
    wr_cmd_valid_i = 1'b1; wr_cmd_addr_i = 32'h400;
    prevRead = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tcdm_r_valid_i = prevRead ? 2'b11 : 2'b00;
      #1;
      checkOutput($sformatf("rr_pick%0d", k), {rd_cmd_ready_o, wr_cmd_ready_o},
                  expRdOrder[k] ? 2'b10 : 2'b01);
      applyStimulus(1);
      tcdm_r_valid_i = 2'b00;
      #1;
      checkOutput($sformatf("rr_wen%0d", k), tcdm_wen_o, expRdOrder[k] ? 2'b11 : 2'b00);
      prevRead = expRdOrder[k];
      applyStimulus(1);
    end
    rd_cmd_valid_i = 1'b0; wr_cmd_valid_i = 1'b0;
    tcdm_r_valid_i = prevRead ? 2'b11 : 2'b00;
    applyStimulus(1);
    tcdm_r_valid_i = 2'b00;
    #1;
    checkOutput("rr_out_cnt", dut.r_outCnt, 0);

    // Read credits exhausted with responses withheld
    applyStimulus(1);
    $display("[TB] credit limit");
    rd_cmd_valid_i = 1'b1; rd_cmd_addr_i = 32'h500; rd_cmd_id_i = 6'd10; rd_cmd_last_i = 1'b0;
    tcdm_gnt_i = 2'b11;
    #1;
    checkOutput("cr_ready0", rd_cmd_ready_o, 1'b1);
    applyStimulus(1);
    rd_cmd_addr_i = 32'h508; rd_cmd_id_i = 6'd11; rd_cmd_last_i = 1'b1;
    #1;
    checkOutput("cr_wen0", tcdm_wen_o, 2'b11);
    applyStimulus(1);
    #1;
    checkOutput("cr_ready1", rd_cmd_ready_o, 1'b1);
    applyStimulus(2);
    #1;
    checkOutput("cr_blocked0", rd_cmd_ready_o, 1'b0);
    checkOutput("cr_cnt_full", dut.r_outCnt, 2);
    applyStimulus(1);
    #1;
    checkOutput("cr_blocked1", rd_cmd_ready_o, 1'b0);
    checkOutput("cr_no_req", tcdm_req_o, 2'b00);
    applyStimulus(1);
    tcdm_r_valid_i = 2'b11;
    #1;
    checkOutput("cr_pop_id", {rd_push_last_o, rd_push_id_o}, {1'b0, 6'd10});
    checkOutput("cr_blocked2", rd_cmd_ready_o, 1'b0);
    applyStimulus(1);
    tcdm_r_valid_i = 2'b00;
    #1;
    checkOutput("cr_ready_again", rd_cmd_ready_o, 1'b1);
    checkOutput("cr_head_id", {rd_push_last_o, rd_push_id_o}, {1'b1, 6'd11});
    applyStimulus(1);
    rd_cmd_valid_i = 1'b0;
    applyStimulus(1);
    tcdm_r_valid_i = 2'b11;
    applyStimulus(1);
    applyStimulus(1);
    tcdm_r_valid_i = 2'b00;
    #1;
    checkOutput("cr_drained", dut.r_outCnt, 0);

    // Reset in the middle of a write beat
    $display("[TB] reset during write beat");
    rd_cmd_valid_i = 1'b1; rd_cmd_addr_i = 32'h700; rd_cmd_id_i = 6'd3; rd_cmd_last_i = 1'b0;
    tcdm_gnt_i = 2'b11;
    #1;
    checkOutput("mr_rd_ready", rd_cmd_ready_o, 1'b1);
    applyStimulus(1);
    rd_cmd_valid_i = 1'b0;
    applyStimulus(1);
    wr_cmd_valid_i = 1'b1; wr_cmd_addr_i = 32'h600; wr_dat_gnt_i = 2'b11; tcdm_gnt_i = 2'b01;
    #1;
    checkOutput("mr_wr_ready", wr_cmd_ready_o, 1'b1);
    applyStimulus(1);
    wr_cmd_valid_i = 1'b0;
    #1;
    checkOutput("mr_req_c0", tcdm_req_o, 2'b11);
    applyStimulus(1);
    tcdm_gnt_i = 2'b00;
    #1;
    checkOutput("mr_req_c1", tcdm_req_o, 2'b10);
    checkOutput("mr_cnt_before", dut.r_outCnt, 1);
    #2;
    rst_ni = 1'b0; tcdm_r_valid_i = 2'b11;
    #1;
    checkOutput("mr_req_rst", tcdm_req_o, 2'b00);
    checkOutput("mr_add_rst", tcdm_add_o, 0);
    checkOutput("mr_wdata_rst", tcdm_wdata_o, 0);
    checkOutput("mr_be_rst", tcdm_be_o, 0);
    checkOutput("mr_datreq_rst", wr_dat_req_o, 2'b00);
    checkOutput("mr_push_rst", rd_push_req_o, 2'b00);
    rst_ni = 1'b1; tcdm_r_valid_i = 2'b00;
    #1;
    checkOutput("mr_state_arb", dut.r_state, ST_ARB);
    checkOutput("mr_cnt_zero", dut.r_outCnt, 0);
    checkOutput("mr_done_zero", dut.r_done, 2'b00);
    rd_cmd_valid_i = 1'b1; wr_cmd_valid_i = 1'b1;
    #1;
    checkOutput("mr_first_pick", {rd_cmd_ready_o, wr_cmd_ready_o}, expFirstPick);
    rd_cmd_valid_i = 1'b0; wr_cmd_valid_i = 1'b0;

    applyStimulus(2);
    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
